// File: rtl/bin_decode_ctrl.sv
// Bin decode controller: turns regular/bypass bin commands into decoder steps,
// keeps the bitstream bit budget and feeds bytes into the arithmetic decoder.
module bin_decode_ctrl #(
   parameter int unsigned BIN_WIDTH = 3,
   parameter int unsigned CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [7:0]           cmd_pstate,
   input  logic                 cmd_bypass,
   input  logic [6:0]           cmd_nbins,
   output logic                 dec_en,
   output logic                 dec_bypass,
   output logic [7:0]           dec_pstate,
   output logic [2:0]           dec_nbin,
   input  logic [2:0]           dec_numbits,
   input  logic                 dec_renorm,
   input  logic [BIN_WIDTH-1:0] dec_bins,
   input  logic                 byte_valid,
   input  logic [7:0]           byte_data,
   output logic                 byte_ready,
   output logic                 feed_valid,
   output logic [7:0]           feed_byte,
   output logic [2:0]           feed_shift,
   output logic [2:0]           feed_lane,
   output logic                 bin_valid,
   output logic [BIN_WIDTH-1:0] bin_data,
   output logic [2:0]           bin_cnt,
   output logic [CNT_W-1:0]     bins_total,
   output logic                 busy
);

   localparam int unsigned REM_W = 7;
   localparam int unsigned NB_W  = 3;
   localparam int unsigned BN_W  = 4;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state;
   logic [REM_W-1:0]       remaining;
   logic [BN_W-1:0]        bits_needed;
   logic [7:0]             pstate_q;
   logic                   bypass_q;
   logic                   bin_valid_q;
   logic [BIN_WIDTH-1:0]   bin_data_q;
   logic [NB_W-1:0]        bin_cnt_q;
   logic [CNT_W-1:0]       total_q;

   logic [NB_W-1:0]        n;
   logic [NB_W-1:0]        add;
   logic [BN_W:0]          s;
   logic                   need_byte;
   logic                   step;
   logic                   take;
   logic [BIN_WIDTH-1:0]   bin_mask;

   // Step sizing and bit budget; bits_needed is signed, s is its sign-extended sum.
   always_comb begin
      n         = '0;
      add       = '0;
      s         = '0;
      need_byte = 1'b0;
      step      = 1'b0;
      take      = 1'b0;
      bin_mask  = '0;
      if (state == RUN) begin
         if (bypass_q) begin
            n   = (remaining < REM_W'(BIN_WIDTH)) ? remaining[NB_W-1:0] : NB_W'(BIN_WIDTH);
            add = n;
         end else begin
            n   = NB_W'(1);
            add = dec_renorm ? dec_numbits : '0;
         end
         s         = {bits_needed[BN_W-1], bits_needed} + {2'b00, add};
         need_byte = ~s[BN_W];
         step      = reset & (~need_byte | byte_valid);
         take      = step & need_byte;
      end
      for (int unsigned i = 0; i < BIN_WIDTH; i++) begin
         if (NB_W'(i) < n) bin_mask[i] = 1'b1;
      end
   end

   // Command FSM, bit budget and bin emission registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         remaining   <= '0;
         bits_needed <= BN_W'(4'b1000);
         pstate_q    <= '0;
         bypass_q    <= 1'b0;
         bin_valid_q <= 1'b0;
         bin_data_q  <= '0;
         bin_cnt_q   <= '0;
         total_q     <= '0;
      end else begin
         bin_valid_q <= step;
         bin_data_q  <= step ? (dec_bins & bin_mask) : '0;
         bin_cnt_q   <= step ? (n - NB_W'(1)) : '0;
         if (step) total_q <= total_q + CNT_W'(n);
         case (state)
            IDLE: begin
               if (cmd_valid && (cmd_nbins != '0)) begin
                  pstate_q  <= cmd_pstate;
                  bypass_q  <= cmd_bypass;
                  remaining <= cmd_nbins;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (step) begin
                  bits_needed <= take ? (s[BN_W-1:0] - BN_W'(8)) : s[BN_W-1:0];
                  remaining   <= remaining - REM_W'(n);
                  if (remaining == REM_W'(n)) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cmd_ready  = reset & (state == IDLE);
   assign busy       = reset & (state == RUN);
   assign dec_en     = step;
   assign dec_bypass = bypass_q;
   assign dec_pstate = pstate_q;
   assign dec_nbin   = (state == RUN) ? (n - NB_W'(1)) : '0;
   assign byte_ready = take;
   assign feed_valid = take;
   assign feed_byte  = take ? byte_data : '0;
   assign feed_shift = take ? s[NB_W-1:0] : '0;
   // -bits_needed-1 is the bitwise inverse in two's complement.
   assign feed_lane  = take ? ~bits_needed[NB_W-1:0] : '0;
   assign bin_valid  = reset & bin_valid_q;
   assign bin_data   = reset ? bin_data_q : '0;
   assign bin_cnt    = reset ? bin_cnt_q : '0;
   assign bins_total = total_q;

endmodule

// File: tb/tb_bin_decode_ctrl.sv
// Bench for bin_decode_ctrl: directed scenarios plus randomized traffic
// against an integer-arithmetic model of the bit budget and bin counting.
module tb_bin_decode_ctrl;

   localparam int BW = 3;

   logic          clk;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [7:0]    cmd_pstate;
   logic          cmd_bypass;
   logic [6:0]    cmd_nbins;
   logic          dec_en;
   logic          dec_bypass;
   logic [7:0]    dec_pstate;
   logic [2:0]    dec_nbin;
   logic [2:0]    dec_numbits;
   logic          dec_renorm;
   logic [BW-1:0] dec_bins;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          feed_valid;
   logic [7:0]    feed_byte;
   logic [2:0]    feed_shift;
   logic [2:0]    feed_lane;
   logic          bin_valid;
   logic [BW-1:0] bin_data;
   logic [2:0]    bin_cnt;
   logic [31:0]   bins_total;
   logic          busy;

   bin_decode_ctrl #(.BIN_WIDTH(BW), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pstate(cmd_pstate),
      .cmd_bypass(cmd_bypass), .cmd_nbins(cmd_nbins),
      .dec_en(dec_en), .dec_bypass(dec_bypass), .dec_pstate(dec_pstate),
      .dec_nbin(dec_nbin), .dec_numbits(dec_numbits), .dec_renorm(dec_renorm),
      .dec_bins(dec_bins),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .feed_valid(feed_valid), .feed_byte(feed_byte), .feed_shift(feed_shift),
      .feed_lane(feed_lane),
      .bin_valid(bin_valid), .bin_data(bin_data), .bin_cnt(bin_cnt),
      .bins_total(bins_total), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: plain integers for the command and bit budget.
   bit          m_run;
   int          m_rem;
   int          m_bn;
   logic [31:0] m_total;
   bit          m_byp;
   logic [7:0]  m_ps;
   bit          m_bv;
   int          m_bdata;
   int          m_bcnt;
   int          e_n, e_s;
   bit          e_step, e_take;

   task automatic model_eval();
      int add;
      e_n = 0; e_s = 0; e_step = 0; e_take = 0;
      if (reset && m_run) begin
         e_n = m_byp ? ((m_rem < BW) ? m_rem : BW) : 1;
         add = m_byp ? e_n : (dec_renorm ? int'(dec_numbits) : 0);
         e_s = m_bn + add;
         if (e_s < 0) e_step = 1;
         else if (byte_valid) begin e_step = 1; e_take = 1; end
      end
   endtask

   task automatic model_update();
      if (!reset) begin
         m_run = 0; m_rem = 0; m_bn = -8; m_total = '0;
         m_byp = 0; m_ps = '0; m_bv = 0;
      end else if (m_run) begin
         m_bv = e_step;
         if (e_step) begin
            m_bdata = int'(dec_bins) & ((1 << e_n) - 1);
            m_bcnt  = e_n - 1;
            m_total = m_total + 32'(e_n);
            m_rem   = m_rem - e_n;
            m_bn    = e_take ? e_s - 8 : e_s;
            if (m_rem == 0) m_run = 0;
         end
      end else begin
         m_bv = 0;
         if (cmd_valid && cmd_nbins != 0) begin
            m_run = 1; m_rem = int'(cmd_nbins); m_byp = cmd_bypass; m_ps = cmd_pstate;
         end
      end
   endtask

   task automatic settle();
      #1;
      model_eval();
   endtask

   task automatic tick();
      model_eval();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic run_cmd(input bit byp, input int nb);
      cmd_valid = 1; cmd_bypass = byp; cmd_nbins = 7'(nb); cmd_pstate = 8'h00;
      byte_valid = 1; dec_renorm = 0;
      tick();
      cmd_valid = 0;
      for (int i = 0; i < 300 && m_run; i++) tick();
   endtask

   task automatic test_reset();
      reset = 0; cmd_valid = 0; cmd_bypass = 0; cmd_nbins = '0; cmd_pstate = '0;
      dec_numbits = '0; dec_renorm = 0; dec_bins = '0; byte_valid = 0; byte_data = '0;
      settle();
      n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready: got %0d want 0", cmd_ready); end
      n_cmp++; if (dec_en !== 1'b0) begin n_bad++; $display("FAIL rst_dec_en: got %0d want 0", dec_en); end
      n_cmp++; if (bin_valid !== 1'b0) begin n_bad++; $display("FAIL rst_bin_valid: got %0d want 0", bin_valid); end
      tick(); tick();
      settle();
      n_cmp++; if (bins_total !== 32'd0) begin n_bad++; $display("FAIL rst_bins_total: got %0d want 0", bins_total); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0d want 0", busy); end
      n_cmp++; if (dec_pstate !== 8'd0 || dec_bypass !== 1'b0) begin n_bad++; $display("FAIL rst_latch: got %0d/%0d want 0/0", dec_pstate, dec_bypass); end
      n_cmp++; if (bin_cnt !== 3'd0 || bin_data !== '0) begin n_bad++; $display("FAIL rst_bin_out: got %0d/%0d want 0/0", bin_cnt, bin_data); end
      reset = 1;
      settle();
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL idle_cmd_ready: got %0d want 1", cmd_ready); end
   endtask

   task automatic test_bypass_split();
      int exp_nbin [3] = '{2, 2, 0};
      cmd_valid = 1; cmd_bypass = 1; cmd_nbins = 7'd7; cmd_pstate = 8'h5A;
      byte_valid = 1; byte_data = 8'($urandom); dec_bins = '1;
      settle();
      n_cmp++; if (cmd_ready !== 1'b1 || dec_en !== 1'b0) begin n_bad++; $display("FAIL byp7_accept: got %0d/%0d want 1/0", cmd_ready, dec_en); end
      tick();
      cmd_valid = 0;
      for (int k = 0; k < 3; k++) begin
         settle();
         n_cmp++; if (dec_en !== 1'b1) begin n_bad++; $display("FAIL byp7_dec_en%0d: got %0d want 1", k, dec_en); end
         n_cmp++; if (dec_nbin !== 3'(exp_nbin[k])) begin n_bad++; $display("FAIL byp7_nbin%0d: got %0d want %0d", k, dec_nbin, exp_nbin[k]); end
         n_cmp++; if (feed_valid !== 1'b0 || byte_ready !== 1'b0) begin n_bad++; $display("FAIL byp7_nobyte%0d: got %0d/%0d want 0/0", k, feed_valid, byte_ready); end
         n_cmp++; if (busy !== 1'b1 || cmd_ready !== 1'b0 || dec_bypass !== 1'b1) begin n_bad++; $display("FAIL byp7_run%0d: got %0d%0d%0d want 101", k, busy, cmd_ready, dec_bypass); end
         if (k == 1) begin
            n_cmp++; if (bin_valid !== 1'b1 || bin_data !== 3'b111 || bin_cnt !== 3'd2) begin n_bad++; $display("FAIL byp7_bin1: got %0d/%0d/%0d want 1/7/2", bin_valid, bin_data, bin_cnt); end
         end
         tick();
      end
      settle();
      n_cmp++; if (bin_valid !== 1'b1 || bin_data !== 3'b001 || bin_cnt !== 3'd0) begin n_bad++; $display("FAIL byp7_last_bin: got %0d/%0d/%0d want 1/1/0", bin_valid, bin_data, bin_cnt); end
      n_cmp++; if (bins_total !== 32'd7) begin n_bad++; $display("FAIL byp7_total: got %0d want 7", bins_total); end
      n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL byp7_idle: got %0d/%0d want 0/1", busy, cmd_ready); end
   endtask

   // bits_needed walks -1 -> -8 -> -3 before the regular step, then -5, -2, -7.
   task automatic test_regular_and_lane();
      run_cmd(1, 1);
      run_cmd(1, 5);
      cmd_valid = 1; cmd_bypass = 0; cmd_nbins = 7'd1; cmd_pstate = 8'hC3;
      tick();
      cmd_valid = 0; dec_renorm = 1; dec_numbits = 3'd6; byte_valid = 1; byte_data = 8'hA5;
      settle();
      n_cmp++; if (dec_en !== 1'b1 || dec_bypass !== 1'b0 || dec_pstate !== 8'hC3 || dec_nbin !== 3'd0) begin n_bad++; $display("FAIL reg_step: got %0d/%0d/%0h/%0d want 1/0/c3/0", dec_en, dec_bypass, dec_pstate, dec_nbin); end
      n_cmp++; if (byte_ready !== 1'b1 || feed_valid !== 1'b1 || feed_byte !== 8'hA5) begin n_bad++; $display("FAIL reg_feed: got %0d/%0d/%0h want 1/1/a5", byte_ready, feed_valid, feed_byte); end
      n_cmp++; if (feed_shift !== 3'd3 || feed_lane !== 3'd2) begin n_bad++; $display("FAIL reg_shift_lane: got %0d/%0d want 3/2", feed_shift, feed_lane); end
      tick();
      dec_renorm = 0;
      cmd_valid = 1; cmd_bypass = 1; cmd_nbins = 7'd3;
      tick();
      cmd_valid = 0;
      settle();
      n_cmp++; if (dec_en !== 1'b1 || feed_valid !== 1'b0) begin n_bad++; $display("FAIL byp_m5: got %0d/%0d want 1/0", dec_en, feed_valid); end
      tick();
      cmd_valid = 1;
      tick();
      cmd_valid = 0; byte_data = 8'h3C;
      settle();
      n_cmp++; if (feed_valid !== 1'b1 || feed_lane !== 3'd1 || feed_shift !== 3'd1 || feed_byte !== 8'h3C) begin n_bad++; $display("FAIL byp_lane: got %0d/%0d/%0d/%0h want 1/1/1/3c", feed_valid, feed_lane, feed_shift, feed_byte); end
      n_cmp++; if (dec_nbin !== 3'd2) begin n_bad++; $display("FAIL byp_lane_nbin: got %0d want 2", dec_nbin); end
      tick();
   endtask

   task automatic test_stall();
      logic [31:0] t0;
      cmd_valid = 1; cmd_bypass = 0; cmd_nbins = 7'd2; cmd_pstate = 8'h11;
      tick();
      cmd_valid = 0; dec_renorm = 1; dec_numbits = 3'd7; byte_valid = 0;
      t0 = m_total;
      for (int k = 0; k < 4; k++) begin
         settle();
         n_cmp++; if (dec_en !== 1'b0 || byte_ready !== 1'b0) begin n_bad++; $display("FAIL stall%0d: got %0d/%0d want 0/0", k, dec_en, byte_ready); end
         n_cmp++; if (bins_total !== t0 || bin_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL stall_hold%0d: got %0d/%0d/%0d want %0d/0/1", k, bins_total, bin_valid, busy, t0); end
         tick();
      end
      byte_valid = 1; byte_data = 8'hE7;
      settle();
      n_cmp++; if (dec_en !== 1'b1 || byte_ready !== 1'b1 || feed_shift !== 3'd0 || feed_lane !== 3'd6) begin n_bad++; $display("FAIL stall_go: got %0d/%0d/%0d/%0d want 1/1/0/6", dec_en, byte_ready, feed_shift, feed_lane); end
      tick();
      dec_renorm = 0;
      settle();
      n_cmp++; if (dec_en !== 1'b1 || feed_valid !== 1'b0 || bin_valid !== 1'b1) begin n_bad++; $display("FAIL stall_next: got %0d/%0d/%0d want 1/0/1", dec_en, feed_valid, bin_valid); end
      tick();
      settle();
      n_cmp++; if (bins_total !== t0 + 32'd2) begin n_bad++; $display("FAIL stall_total: got %0d want %0d", bins_total, t0 + 32'd2); end
   endtask

   task automatic test_zero_cmd();
      cmd_valid = 1; cmd_bypass = 1; cmd_nbins = 7'd0;
      settle();
      n_cmp++; if (cmd_ready !== 1'b1 || dec_en !== 1'b0) begin n_bad++; $display("FAIL zero_accept: got %0d/%0d want 1/0", cmd_ready, dec_en); end
      tick();
      cmd_valid = 0;
      for (int k = 0; k < 2; k++) begin
         settle();
         n_cmp++; if (busy !== 1'b0 || bin_valid !== 1'b0 || dec_en !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL zero_idle%0d: got %0d%0d%0d%0d want 0001", k, busy, bin_valid, dec_en, cmd_ready); end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      cmd_valid = 1; cmd_bypass = 1; cmd_nbins = 7'd8; byte_valid = 1;
      tick();
      cmd_valid = 0;
      tick();
      reset = 0;
      settle();
      n_cmp++; if (dec_en !== 1'b0 || bin_valid !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_during: got %0d%0d%0d%0d want 0000", dec_en, bin_valid, cmd_ready, busy); end
      tick();
      reset = 1;
      settle();
      n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || bin_valid !== 1'b0 || bins_total !== 32'd0) begin n_bad++; $display("FAIL midrst_after: got %0d/%0d/%0d/%0d want 0/1/0/0", busy, cmd_ready, bin_valid, bins_total); end
      cmd_valid = 1; cmd_nbins = 7'd7;
      tick();
      cmd_valid = 0;
      for (int k = 0; k < 3; k++) begin
         settle();
         n_cmp++; if (dec_en !== 1'b1 || feed_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_budget%0d: got %0d/%0d want 1/0", k, dec_en, feed_valid); end
         tick();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         reset       = ($urandom_range(0, 149) != 0);
         cmd_valid   = ($urandom_range(0, 3) == 0);
         cmd_bypass  = 1'($urandom);
         cmd_pstate  = 8'($urandom);
         cmd_nbins   = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 12));
         dec_numbits = 3'($urandom);
         dec_renorm  = 1'($urandom);
         dec_bins    = BW'($urandom);
         byte_valid  = ($urandom_range(0, 9) < 7);
         byte_data   = 8'($urandom);
         settle();
         n_cmp++; if (cmd_ready !== (reset && !m_run)) begin n_bad++; $display("FAIL rnd_cmd_ready c%0d: got %0d want %0d", c, cmd_ready, reset && !m_run); end
         n_cmp++; if (busy !== (reset && m_run)) begin n_bad++; $display("FAIL rnd_busy c%0d: got %0d want %0d", c, busy, reset && m_run); end
         n_cmp++; if (dec_en !== e_step) begin n_bad++; $display("FAIL rnd_dec_en c%0d: got %0d want %0d", c, dec_en, e_step); end
         n_cmp++; if (byte_ready !== e_take || feed_valid !== e_take) begin n_bad++; $display("FAIL rnd_take c%0d: got %0d/%0d want %0d", c, byte_ready, feed_valid, e_take); end
         n_cmp++; if (bin_valid !== (reset && m_bv)) begin n_bad++; $display("FAIL rnd_bin_valid c%0d: got %0d want %0d", c, bin_valid, reset && m_bv); end
         n_cmp++; if (bins_total !== m_total) begin n_bad++; $display("FAIL rnd_total c%0d: got %0d want %0d", c, bins_total, m_total); end
         n_cmp++; if (dec_bypass !== m_byp || dec_pstate !== m_ps) begin n_bad++; $display("FAIL rnd_latch c%0d: got %0d/%0h want %0d/%0h", c, dec_bypass, dec_pstate, m_byp, m_ps); end
         if (reset && m_run) begin
            n_cmp++; if (dec_nbin !== 3'(e_n - 1)) begin n_bad++; $display("FAIL rnd_nbin c%0d: got %0d want %0d", c, dec_nbin, e_n - 1); end
         end
         if (e_take) begin
            n_cmp++; if (feed_byte !== byte_data || feed_shift !== 3'(e_s) || feed_lane !== 3'(-m_bn - 1)) begin n_bad++; $display("FAIL rnd_feed c%0d: got %0h/%0d/%0d want %0h/%0d/%0d", c, feed_byte, feed_shift, feed_lane, byte_data, e_s, -m_bn - 1); end
         end
         if (reset && m_bv) begin
            n_cmp++; if (bin_data !== BW'(m_bdata) || bin_cnt !== 3'(m_bcnt)) begin n_bad++; $display("FAIL rnd_bins c%0d: got %0d/%0d want %0d/%0d", c, bin_data, bin_cnt, m_bdata, m_bcnt); end
         end
         tick();
      end
   endtask

   initial begin
      m_run = 0; m_rem = 0; m_bn = -8; m_total = '0; m_byp = 0; m_ps = '0;
      m_bv = 0; m_bdata = 0; m_bcnt = 0;
      test_reset();
      test_bypass_split();
      test_regular_and_lane();
      test_stall();
      test_zero_cmd();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
